// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serializer slice.
package alu_pkg;
    localparam int WORD_W  = 16;
    localparam int N_WORDS = 8;
    localparam int IDX_W   = $clog2(N_WORDS);

    typedef struct packed {
        logic carry;
        logic greater;
        logic equal;
        logic less;
    } alu_flags_t;

    typedef enum logic {IDLE, SEND} ser_state_t;
endpackage

// File: rtl/alu_next_word_sel.sv
// Mask walker: next set word above the current index, and the first set word
// of an incoming frame's mask.
module alu_next_word_sel
    import alu_pkg::*;
(
    input  logic [N_WORDS-1:0] cur_mask,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic [N_WORDS-1:0] load_mask,
    output logic [IDX_W-1:0]   next_idx,
    output logic               has_next,
    output logic [IDX_W-1:0]   lowest_idx
);
    // Descending scans so the lowest qualifying bit is the one left standing.
    always_comb begin
        next_idx   = '0;
        has_next   = 1'b0;
        lowest_idx = '0;
        for (int k = N_WORDS - 1; k >= 0; k--) begin
            if (cur_mask[k] && (k > int'(cur_idx))) begin
                next_idx = IDX_W'(k);
                has_next = 1'b1;
            end
            if (load_mask[k])
                lowest_idx = IDX_W'(k);
        end
    end
endmodule

// File: rtl/alu_result_serializer.sv
// Captures an eight-word ALU result frame and streams the masked words out
// one per beat, with gapless hand-over to the next frame on the last beat.
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int n_alu = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH*n_alu*N_WORDS-1:0] in_data,
    input  logic [N_WORDS-1:0]             in_mask,
    input  logic                           in_carry,
    input  logic                           in_greater,
    input  logic                           in_equal,
    input  logic                           in_less,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH*n_alu-1:0]         out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last,
    output logic [3:0]                     out_flags,
    output logic                           busy
);
    localparam int W = WIDTH * n_alu;

    ser_state_t                 state;
    logic [N_WORDS-1:0][W-1:0]  data_q;
    logic [N_WORDS-1:0][W-1:0]  in_words;
    logic [N_WORDS-1:0]         mask_q;
    alu_flags_t                 flags_q;
    logic [IDX_W-1:0]           next_idx;
    logic [IDX_W-1:0]           first_idx;
    logic                       has_next;
    logic                       load;

    assign in_words = in_data;

    alu_next_word_sel u_sel (
        .cur_mask   (mask_q),
        .cur_idx    (out_idx),
        .load_mask  (in_mask),
        .next_idx   (next_idx),
        .has_next   (has_next),
        .lowest_idx (first_idx)
    );

    // All beat-side outputs decode from registers; only in_ready sees out_ready.
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign out_last  = out_valid & ~has_next;
    assign out_flags = flags_q;
    assign in_ready  = rst & ((state == IDLE) | (out_last & out_ready));
    assign load      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            flags_q  <= '0;
            out_idx  <= '0;
            out_data <= '0;
        end else if (load) begin
            // An all-zero mask consumes the frame without producing beats.
            if (|in_mask) begin
                data_q   <= in_words;
                mask_q   <= in_mask;
                flags_q  <= '{carry: in_carry, greater: in_greater,
                              equal: in_equal, less: in_less};
                out_idx  <= first_idx;
                out_data <= in_words[first_idx];
                state    <= SEND;
            end else begin
                state <= IDLE;
            end
        end else if (state == SEND && out_ready) begin
            if (out_last) begin
                state <= IDLE;
            end else begin
                out_idx  <= next_idx;
                out_data <= data_q[next_idx];
            end
        end
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed plus randomized bench; expected beats come from a queue model
// built from each accepted frame's mask.
module tb_alu_result_serializer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data;
    logic [7:0]   in_mask = '0;
    logic         in_carry = 1'b0, in_greater = 1'b0, in_equal = 1'b0, in_less = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic [3:0]   out_flags;
    logic         busy;

    logic [7:0][15:0] words = '0;
    assign in_data = words;

    always #5 clk = ~clk;

    alu_result_serializer #(.WIDTH(4), .n_alu(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .in_carry   (in_carry),
        .in_greater (in_greater),
        .in_equal   (in_equal),
        .in_less    (in_less),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        last;
        logic [3:0]  flags;
    } beat_t;

    beat_t q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] m, input logic [3:0] f,
                         input logic [15:0] base, input logic rdy);
        in_valid = v;
        in_mask  = m;
        {in_carry, in_greater, in_equal, in_less} = f;
        for (int k = 0; k < 8; k++) words[k] = base + 16'(k);
        out_ready = rdy;
    endtask

    task automatic push_frame();
        int   last_k;
        beat_t b;
        last_k = -1;
        for (int k = 0; k < 8; k++) if (in_mask[k]) last_k = k;
        for (int k = 0; k < 8; k++) begin
            if (in_mask[k]) begin
                b.idx   = k;
                b.data  = words[k];
                b.last  = (k == last_k);
                b.flags = {in_carry, in_greater, in_equal, in_less};
                q.push_back(b);
            end
        end
    endtask

    // One clock: check at the falling edge, then advance the model.
    task automatic cycle();
        logic exp_valid, exp_ready;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_valid) begin
            chk("out_idx", 32'(out_idx), q[0].idx);
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_last", 32'(out_last), 32'(q[0].last));
            chk("out_flags", 32'(out_flags), 32'(q[0].flags));
            if (out_ready) void'(q.pop_front());
        end
        if (in_valid && exp_ready) push_frame();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        drive(1'b0, 8'h00, 4'h0, 16'h0, 1'b1);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset values while held low
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full mask, consecutive beats 0..7
        drive(1'b1, 8'hFF, 4'b0101, 16'h1000, 1'b1);
        cycle();
        drain(10);

        // Sparse mask with carry and equal
        drive(1'b1, 8'b1010_0100, 4'b1010, 16'h2000, 1'b1);
        cycle();
        drain(5);

        // Backpressure 1,0,0,1
        drive(1'b1, 8'h03, 4'b0001, 16'h3000, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 4'h0, 16'h0, 1'b1);
        cycle();
        out_ready = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b1;
        cycle();
        drain(3);

        // Back-to-back hand-over on the last beat
        drive(1'b1, 8'h80, 4'b1100, 16'h4000, 1'b1);
        cycle();
        drive(1'b1, 8'h01, 4'b0011, 16'h5000, 1'b1);
        cycle();
        drain(4);

        // Empty mask frame is swallowed
        drive(1'b1, 8'h00, 4'b1111, 16'h6000, 1'b1);
        cycle();
        drain(3);

        // Asynchronous reset after beat 3
        drive(1'b1, 8'hFF, 4'b1001, 16'h7000, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 4'h0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_last", 32'(out_last), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        drive(1'b1, 8'hFF, 4'b0110, 16'h8000, 1'b1);
        cycle();
        drain(10);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            {in_carry, in_greater, in_equal, in_less} = 4'($urandom);
            for (int k = 0; k < 8; k++) words[k] = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the vector ALU. Captures one full ALU result frame per handshake: the eight-word `data_out` plus the carry and compare flags.
- Emits the frame as a stream of one word per beat on a narrow valid/ready bus.
- A per-frame word mask selects which of the eight op results are sent. Masked words are skipped with no bubble cycles.

Parameters:
- WIDTH, 4, bit width of one ALU slice
- n_alu, 4, number of ALU slices; WORD_W = WIDTH*n_alu (16)
- N_WORDS, 8, result words per ALU frame (fixed by ALU op count)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- in_valid  input  1  ALU frame available
- in_ready  output  1  serializer can accept frame
- in_data  input  WIDTH*n_alu*8  ALU data_out; word k = bits [k*WORD_W +: WORD_W]
- in_mask  input  8  bit k=1: emit word k
- in_carry, in_greater, in_equal, in_less  input  1 each  ALU flags
- out_valid  output  1  beat valid
- out_ready  input  1  sink accepts beat
- out_data  output  WORD_W  current word
- out_idx  output  3  index k of current word
- out_last  output  1  final beat of frame
- out_flags  output  4  {carry, greater, equal, less} of current frame, constant per frame
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid=0, out_last=0, out_data=0, out_idx=0, out_flags=0, busy=0; in_ready=0 while rst=0. Shadow data/mask registers are cleared.
- Reset mid-frame: the frame is dropped and no further beats are sent. After release the block is in IDLE with in_ready=1.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready with in_mask!=0: capture data, mask and flags. Load out_idx with the lowest set mask bit. Go to SEND. out_valid=1 from the next cycle (1-cycle latency, registered outputs).
  - in_mask==0: the frame is accepted and discarded; stay IDLE; no beats.
- SEND:
  - out_valid=1. out_data = shadow word out_idx.
  - out_last=1 when no mask bit above out_idx is set.
  - Stall (out_ready=0): out_data, out_idx, out_last and out_flags hold stable.
  - Beat (out_valid&out_ready, not last): out_idx moves to the next higher set mask bit in the next cycle.
  - Last beat: if in_valid is high the same cycle, the next frame is accepted (in_ready=1 only during a last beat with out_ready=1) and the first beat of the new frame follows next cycle. This gives a gapless back-to-back stream.
  - Last beat with no in_valid, or a new frame with mask 0: go to IDLE and out_valid=0 next cycle.
- in_ready is combinational: (state==IDLE) | (SEND & out_last & out_ready). This is the only combinational input-to-output path.
- Throughput: popcount(mask) beats per frame, one beat per cycle when out_ready=1.
- in_data, in_mask and in_flags are ignored whenever in_ready=0.

Decomposition:
- Shared package alu_pkg:
  - WORD_W, N_WORDS constants
  - typedef alu_flags_t (packed struct carry/greater/equal/less)
  - typedef ser_state_t enum {IDLE, SEND}
- One sub-module: alu_next_word_sel (combinational).
  - Inputs: 8-bit mask, current idx.
  - Outputs: next set index above idx, has_next flag, and lowest set index (used on frame load).
- Top holds the FSM, the shadow registers and the handshake.

Test Plan:
- Full mask: in_mask=8'hFF, word k = 16'h1000+k, out_ready=1 -> eight beats on consecutive cycles, out_idx 0..7, out_data 1000..1007, out_last only on idx 7, in_ready=0 during beats 0..6.
- Sparse mask and flags: in_mask=8'b1010_0100, carry=1, equal=1 -> three beats with idx 2, 5, 7; out_last on idx 7; out_flags=4'b1010 on every beat.
- Backpressure: in_mask=8'h03, out_ready toggling 1,0,0,1 -> idx 0 accepted at cycle 1; idx 1 held stable for two stall cycles, then accepted; no beat duplicated or lost.
- Back-to-back: frame A mask 8'h80, frame B mask 8'h01, in_valid held -> beat A7 (last) then B0 in the next cycle; in_ready=1 only in the A7 handshake cycle.
- Empty mask: in_mask=0, in_valid=1 for one cycle -> frame accepted; out_valid stays 0; state stays IDLE; busy=0.
- Reset mid-frame: mask 8'hFF, rst=0 asynchronously after beat 3 -> out_valid, out_last and busy drop immediately without waiting for a clock; after release, in_ready=1 and a new frame starts at idx 0.
